// File: rtl/lutram_seq_pkg.sv
// Opcodes and FSM state encoding shared by the LUTRAM command sequencer.
package lutram_seq_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_MARCH = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_RD    = 4'd1,
        ST_WR    = 4'd2,
        ST_MW0   = 4'd3,
        ST_MR0   = 4'd4,
        ST_MW1   = 4'd5,
        ST_MR1   = 4'd6,
        ST_DRAIN = 4'd7,
        ST_DONE  = 4'd8
    } state_e;

endpackage

// File: rtl/lutram_seq_cmp.sv
// March read checker: aligns issued address/expectation with returning read
// data, counts mismatches (saturating) and latches the first failing address.
module lutram_seq_cmp
    import lutram_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 0,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  chk_en_i,
    input  logic [DATA_WIDTH-1:0] chk_exp_i,
    input  logic [ADDR_WIDTH-1:0] chk_addr_i,
    input  logic [DATA_WIDTH-1:0] ram_do_i,
    output logic [ERR_WIDTH-1:0]  err_cnt_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic                  fail_vld_o
);

    localparam logic [ERR_WIDTH-1:0] ERR_MAX = {ERR_WIDTH{1'b1}};

    logic                  pipe_en_s;
    logic [DATA_WIDTH-1:0] pipe_exp_s;
    logic [ADDR_WIDTH-1:0] pipe_addr_s;
    logic                  mism_s;
    logic [ERR_WIDTH-1:0]  err_cnt_r;
    logic [ADDR_WIDTH-1:0] fail_addr_r;
    logic                  fail_vld_r;

    generate
        if (RD_LATENCY == 32'sd0) begin : g_lat0
            assign pipe_en_s   = chk_en_i;
            assign pipe_exp_s  = chk_exp_i;
            assign pipe_addr_s = chk_addr_i;
        end else begin : g_lat1
            logic                  en_r;
            logic [DATA_WIDTH-1:0] exp_r;
            logic [ADDR_WIDTH-1:0] addr_r;

            // Delay the read tag by one cycle to meet the registered RAM output.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    en_r   <= 1'b0;
                    exp_r  <= '0;
                    addr_r <= '0;
                end else begin
                    en_r   <= chk_en_i;
                    exp_r  <= chk_exp_i;
                    addr_r <= chk_addr_i;
                end
            end

            assign pipe_en_s   = en_r;
            assign pipe_exp_s  = exp_r;
            assign pipe_addr_s = addr_r;
        end
    endgenerate

    assign mism_s = pipe_en_s && (ram_do_i != pipe_exp_s);

    // Mismatch counter and first-fail latch, cleared when a march starts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_r   <= '0;
            fail_addr_r <= '0;
            fail_vld_r  <= 1'b0;
        end else if (clr_i) begin
            err_cnt_r   <= '0;
            fail_addr_r <= '0;
            fail_vld_r  <= 1'b0;
        end else if (mism_s) begin
            if (err_cnt_r != ERR_MAX) begin
                err_cnt_r <= err_cnt_r + 1'b1;
            end
            if (!fail_vld_r) begin
                fail_addr_r <= pipe_addr_s;
                fail_vld_r  <= 1'b1;
            end
        end
    end

    assign err_cnt_o   = err_cnt_r;
    assign fail_addr_o = fail_addr_r;
    assign fail_vld_o  = fail_vld_r;

endmodule

// File: rtl/lutram_seq.sv
// LUTRAM command sequencer: single READ/WRITE accesses plus a four-phase march
// test (write P up, read P up, write ~P down, read ~P down).
module lutram_seq
    import lutram_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 0,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    input  logic [1:0]            cmd_op_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_di_o,
    input  logic [DATA_WIDTH-1:0] ram_do_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [ERR_WIDTH-1:0]  err_cnt_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic                  fail_vld_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    // Last RD cycle index and whether a drain cycle follows each read phase.
    localparam logic LAT_LAST  = (RD_LATENCY != 32'sd0) ? 1'b1 : 1'b0;
    localparam logic HAS_DRAIN = LAT_LAST;

    state_e                state_r, state_next_s;
    logic [ADDR_WIDTH-1:0] ram_addr_r, addr_next_s;
    logic [DATA_WIDTH-1:0] ram_di_r, di_next_s;
    logic [DATA_WIDTH-1:0] pat_r, pat_next_s;
    logic [DATA_WIDTH-1:0] rdata_r, rdata_next_s;
    logic                  ram_we_r, busy_r, done_r;
    logic                  lat_r, lat_next_s;
    logic                  post_mr1_r, post_mr1_next_s;
    logic                  nop_acc_s, march_acc_s;

    // Next-state, address counter and write-data selection.
    always_comb begin
        state_next_s    = state_r;
        addr_next_s     = ram_addr_r;
        di_next_s       = ram_di_r;
        pat_next_s      = pat_r;
        rdata_next_s    = rdata_r;
        lat_next_s      = 1'b0;
        post_mr1_next_s = post_mr1_r;
        nop_acc_s       = 1'b0;
        march_acc_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    case (cmd_op_i)
                        OP_NOP: nop_acc_s = 1'b1;
                        OP_READ: begin
                            state_next_s = ST_RD;
                            addr_next_s  = cmd_addr_i;
                        end
                        OP_WRITE: begin
                            state_next_s = ST_WR;
                            addr_next_s  = cmd_addr_i;
                            di_next_s    = cmd_data_i;
                        end
                        OP_MARCH: begin
                            state_next_s    = ST_MW0;
                            addr_next_s     = '0;
                            di_next_s       = cmd_data_i;
                            pat_next_s      = cmd_data_i;
                            post_mr1_next_s = 1'b0;
                            march_acc_s     = 1'b1;
                        end
                        default: state_next_s = ST_IDLE;
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (lat_r == LAT_LAST) begin
                    state_next_s = ST_DONE;
                    rdata_next_s = ram_do_i;
                end else begin
                    lat_next_s = 1'b1;
                end
            end
            ST_WR: state_next_s = ST_DONE;
            ST_MW0: begin
                if (ram_addr_r == ADDR_LAST) begin
                    state_next_s = ST_MR0;
                    addr_next_s  = '0;
                end else begin
                    addr_next_s = ram_addr_r + 1'b1;
                end
            end
            ST_MR0: begin
                if (ram_addr_r != ADDR_LAST) begin
                    addr_next_s = ram_addr_r + 1'b1;
                end else if (HAS_DRAIN) begin
                    state_next_s    = ST_DRAIN;
                    post_mr1_next_s = 1'b0;
                end else begin
                    state_next_s = ST_MW1;
                    addr_next_s  = ADDR_LAST;
                    di_next_s    = ~pat_r;
                end
            end
            ST_DRAIN: begin
                if (post_mr1_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_MW1;
                    addr_next_s  = ADDR_LAST;
                    di_next_s    = ~pat_r;
                end
            end
            ST_MW1: begin
                if (ram_addr_r == '0) begin
                    state_next_s = ST_MR1;
                    addr_next_s  = ADDR_LAST;
                end else begin
                    addr_next_s = ram_addr_r - 1'b1;
                end
            end
            ST_MR1: begin
                if (ram_addr_r != '0) begin
                    addr_next_s = ram_addr_r - 1'b1;
                end else if (HAS_DRAIN) begin
                    state_next_s    = ST_DRAIN;
                    post_mr1_next_s = 1'b1;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State and output registers; RAM port decoded from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            ram_addr_r <= '0;
            ram_di_r   <= '0;
            ram_we_r   <= 1'b0;
            pat_r      <= '0;
            rdata_r    <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            lat_r      <= 1'b0;
            post_mr1_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            ram_addr_r <= addr_next_s;
            ram_di_r   <= di_next_s;
            ram_we_r   <= (state_next_s == ST_WR) || (state_next_s == ST_MW0) ||
                          (state_next_s == ST_MW1);
            pat_r      <= pat_next_s;
            rdata_r    <= rdata_next_s;
            busy_r     <= (state_next_s != ST_IDLE);
            done_r     <= (state_next_s == ST_DONE) || nop_acc_s;
            lat_r      <= lat_next_s;
            post_mr1_r <= post_mr1_next_s;
        end
    end

    lutram_seq_cmp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY),
        .ERR_WIDTH  (ERR_WIDTH)
    ) u_cmp (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (march_acc_s),
        .chk_en_i    ((state_r == ST_MR0) || (state_r == ST_MR1)),
        .chk_exp_i   ((state_r == ST_MR1) ? ~pat_r : pat_r),
        .chk_addr_i  (ram_addr_r),
        .ram_do_i    (ram_do_i),
        .err_cnt_o   (err_cnt_o),
        .fail_addr_o (fail_addr_o),
        .fail_vld_o  (fail_vld_o)
    );

    assign ram_we_o   = ram_we_r;
    assign ram_addr_o = ram_addr_r;
    assign ram_di_o   = ram_di_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign rdata_o    = rdata_r;

endmodule
